muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the EX stage of the MIPS pipeline, executing MULT, MULTU, DIV and DIVU into the architectural HI/LO registers. It runs a fixed 32-iteration shift-add / restoring-divide sequence, holds HI/LO, serves MFHI/MFLO reads, accepts MTHI/MTLO writes, and raises a stall to the hazard logic while a result is pending. The main ALU, under ALU_CONTROL's select, stays free for single-cycle ops during the sequence.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch operation (EX-stage decode of MULT/MULTU/DIV/DIVU)
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- mf_req  in  1  MFHI/MFLO in EX needs HI/LO this cycle
- hi_we, lo_we  in  1 each  MTHI / MTLO write strobes
- wdata  in  32  MTHI/MTLO data
- hi, lo  out  32 each  architectural HI/LO
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- div_zero  out  1  one-cycle pulse with done when divisor was 0
- stall  out  1  = mf_req & (busy | start)

## Operation
- States: IDLE, RUN, FIX.
- IDLE: start=1 latches op, rs_val, rt_val; clears 6-bit iteration count; -> RUN. start with busy=1 is ignored (no relatch, no abort).
- RUN: one iteration per cycle on 64-bit {rem/prod_hi, quot/prod_lo}; count increments; after 32nd iteration -> FIX.
- Multiply: shift-add on magnitudes, 64-bit product → HI (upper), LO (lower).
- Divide: restoring, magnitudes; LO = quotient, HI = remainder.
- Signed ops: operands converted to magnitude on latch; FIX negates product if signs differ, quotient if signs differ, remainder if dividend negative.
- Divisor 0: HI = rs_val, LO = 32'hFFFF_FFFF, div_zero=1 with done; no trap; still takes full latency.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0 (wraps, no flag).
- FIX: HI/LO written at the end of the cycle; -> IDLE; done asserted the following cycle.
- hi_we/lo_we: take effect whenever asserted, including during RUN; an in-flight operation overwrites at FIX. Same-cycle start and write: write applies, result later overwrites.
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, state IDLE. rst mid-sequence aborts; no done.

## Timing
- Start accepted at edge E0; busy=1 from E0 to E0+33 (RUN 32 cycles, FIX 1).
- hi/lo show the result and done=1, busy=0 in the cycle after edge E0+33 (34 cycles after E0).
- stall is combinational; MFHI issued at the same time as start stalls 34 cycles then reads the new value.
- done, div_zero are registered, exactly one cycle wide.
- Back-to-back: a new start is accepted in the cycle done=1.

## Configuration
- MULDIV_SIGNED_EN defined: op[1] selects signed; magnitude conversion and FIX sign correction present.
- Undefined: op[1] ignored, MULT/DIV execute as MULTU/DIVU; sign logic removed; FIX state and 34-cycle latency unchanged.

## Test plan
- MULTU 0xFFFF_FFFF × 2 -> HI=0x0000_0001, LO=0xFFFF_FFFE, done exactly 34 cycles after start edge.
- DIV -7 / 2 (signed build) -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; unsigned build -> LO=0x7FFF_FFFC, HI=0x0000_0001.
- DIVU 100 / 0 -> HI=0x0000_0064, LO=0xFFFF_FFFF, div_zero and done high same single cycle.
- MULT 0x8000_0000 × 0xFFFF_FFFF -> HI=0, LO=0x8000_0000 (signed); HI=0x7FFF_FFFF, LO=0x8000_0000 (unsigned build).
- mf_req held from start: stall=1 for 34 cycles, 0 when done=1; second start during RUN ignored, result of first unchanged.
- rst at RUN iteration 10 -> next cycle busy=0, hi=lo=0, no done pulse; MTHI 0x1234 afterwards -> hi=0x1234 next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide for the EX stage.
// Runs a fixed 32-iteration shift-add multiply or restoring divide into the
// architectural HI/LO registers, serves MTHI/MTLO writes and raises a stall
// when an MFHI/MFLO would read HI/LO while a result is still pending.
//
// Build option: define MULDIV_SIGNED_EN to honour op[1] (MULT/DIV signed).
// Without it op[1] is ignored and every operation runs unsigned; the FIX
// cycle and the 34-cycle latency stay the same in both builds.
//
// Handshake: start is a single-cycle request that is accepted only while
// busy=0 (state IDLE); a start seen while busy=1 is dropped with no effect.
// done (and div_zero, if the divisor was zero) pulse for exactly one cycle,
// in the cycle in which hi/lo first show the new result; a new start may be
// presented in that same cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_req,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic        is_div;
  logic        dz;
  logic [31:0] a_raw;   // dividend as presented, reported in HI on divide-by-zero
  logic [31:0] opnd;    // multiplicand (multiply) or divisor magnitude (divide)
  logic [31:0] acc_hi;  // product high half / partial remainder
  logic [31:0] acc_lo;  // multiplier being consumed / quotient being built

  logic [31:0] a_mag;
  logic [31:0] b_mag;

`ifdef MULDIV_SIGNED_EN
  logic neg_res;        // negate product or quotient at FIX
  logic neg_rem;        // negate remainder at FIX (dividend was negative)
  logic a_neg;
  logic b_neg;

  // Signed operands are reduced to magnitudes as they are latched
  always_comb begin
    a_neg = op[1] & rs_val[31];
    b_neg = op[1] & rt_val[31];
    a_mag = a_neg ? (~rs_val + 32'd1) : rs_val;
    b_mag = b_neg ? (~rt_val + 32'd1) : rt_val;
  end
`else
  logic unused_op1;
  assign unused_op1 = op[1];

  // Unsigned build: operands pass straight through
  always_comb begin
    a_mag = rs_val;
    b_mag = rt_val;
  end
`endif

  logic [32:0] add_sum;
  logic [32:0] sh_rem;
  logic [32:0] diff;
  logic [31:0] nxt_hi;
  logic [31:0] nxt_lo;

  // One iteration: shift-add step for multiply, restoring step for divide
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    sh_rem  = {acc_hi, acc_lo[31]};
    diff    = sh_rem - {1'b0, opnd};
    if (is_div) begin
      // diff[32] set means the trial subtraction borrowed: keep the shifted remainder
      if (!diff[32]) begin
        nxt_hi = diff[31:0];
        nxt_lo = {acc_lo[30:0], 1'b1};
      end else begin
        nxt_hi = sh_rem[31:0];
        nxt_lo = {acc_lo[30:0], 1'b0};
      end
    end else begin
      nxt_hi = add_sum[32:1];
      nxt_lo = {add_sum[0], acc_lo[31:1]};
    end
  end

  logic [63:0] res;

  // Final HI/LO value written in the FIX cycle
  always_comb begin
    res = {acc_hi, acc_lo};
`ifdef MULDIV_SIGNED_EN
    if (is_div) begin
      if (neg_res) res[31:0]  = ~acc_lo + 32'd1;
      if (neg_rem) res[63:32] = ~acc_hi + 32'd1;
    end else if (neg_res) begin
      res = ~{acc_hi, acc_lo} + 64'd1;
    end
`endif
    if (dz) res = {a_raw, 32'hFFFF_FFFF};
  end

  // Sequencer and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 6'd0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      a_raw  <= 32'd0;
      opnd   <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
`ifdef MULDIV_SIGNED_EN
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            cnt    <= 6'd0;
            is_div <= op[0];
            dz     <= op[0] & (rt_val == 32'd0);
            a_raw  <= rs_val;
            opnd   <= op[0] ? b_mag : a_mag;
            acc_hi <= 32'd0;
            acc_lo <= op[0] ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
`endif
          end
        end
        S_RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Completion pulses, one cycle wide, aligned with the HI/LO update
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= (state == S_FIX);
      div_zero <= (state == S_FIX) & dz;
    end
  end

  // HI/LO: operation result at FIX wins over a same-cycle MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == S_FIX) begin
      hi <= res[63:32];
      lo <= res[31:0];
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  assign busy      = (state != S_IDLE);
  assign stall     = mf_req & (busy | start);
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed
// HI/LO results, latency, pulse-width, stall, ignored-start and reset checks.
// Expected values follow MULDIV_SIGNED_EN the same way the design does.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        stall;
  logic [1:0]  dbg_state;

  int vec_cnt;
  int err_cnt;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mf_req    (mf_req),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .stall     (stall),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one operation from a negedge and follow it to its done pulse.
  // Leaves the bench at the negedge in which done=1, so the caller can start
  // the next operation back-to-back.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input bit use_mf, input bit poke);
    int lat;
    int stall_cnt;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    mf_req = use_mf;
    #1;
    stall_cnt = stall ? 1 : 0;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    check({tag, " done low"}, {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 60) begin
      if (use_mf && stall) stall_cnt++;
      if (poke && lat == 5) begin
        start  = 1'b1;
        op     = OP_MULTU;
        rs_val = 32'd5;
        rt_val = 32'd5;
      end else if (poke && lat == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    // done appears in the 34th cycle after the accepting edge, i.e. after edge E0+33
    check({tag, " latency"}, lat, 32'd33);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy end"}, {31'd0, busy}, 32'd0);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    if (use_mf) begin
      check({tag, " stall cycles"}, stall_cnt, 32'd34);
      check({tag, " stall at done"}, {31'd0, stall}, 32'd0);
    end
    mf_req = 1'b0;
  endtask

  initial begin
    int pulses;
    vec_cnt = 0;
    err_cnt = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = 32'd0;
    rt_val = 32'd0;
    mf_req = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    wdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    check("reset state", {30'd0, dbg_state}, 32'd0);

    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
`else
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b0);
`endif
    run_op("divu by 0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("mult min*-1", OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
`else
    run_op("mult min*-1", OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
`endif
    run_op("divu 1000/7", OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 1'b0, 1'b0);
    run_op("multu x9", OP_MULTU, 32'h1234_5678, 32'd9, 32'h0000_0000, 32'hA3D7_0A38, 1'b0, 1'b0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("mult -3*5 mf", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1, 1'b1);
`else
    run_op("mult -3*5 mf", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 1'b1, 1'b1);
`endif
    run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

    // Abort a sequence at iteration 10 with reset
    start  = 1'b1;
    op     = OP_MULTU;
    rs_val = 32'hFFFF_FFFF;
    rt_val = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("abort no done", pulses, 32'd0);

    // MTHI then MTLO
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", hi, 32'h0000_1234);
    check("mthi lo", lo, 32'd0);
    lo_we = 1'b1;
    wdata = 32'hCAFE_0001;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo lo", lo, 32'hCAFE_0001);
    check("mtlo hi", hi, 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
